// File: rtl/uart_fifo_tx.sv
// UART transmitter that drains a show-ahead FIFO: start bit, DBIT data bits LSB first, stop bits.
// Contains its own 16x-oversampling baud divider, restarted on every pop so frames align to the pop.
module uart_fifo_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 163,
    parameter int DVSR_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_r_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state;
    logic [DVSR_W-1:0] div_cnt;
    logic [4:0]        tick_cnt;
    logic [2:0]        bit_cnt;
    logic [DBIT-1:0]   shreg;
    logic [DBIT-1:0]   shreg_shifted;
    logic              s_tick;
    logic              stop_last;
    logic              pop;

    assign s_tick        = (div_cnt == DVSR_W'(DVSR - 1));
    assign stop_last     = (state == STOP) && s_tick && (tick_cnt == 5'(SB_TICK - 1));
    // fifo_empty is only consulted in idle and on the final stop tick, so mid-frame toggles are ignored.
    assign pop           = ~reset && ~fifo_empty && ((state == IDLE) || stop_last);
    assign fifo_rd       = pop;
    assign tx_done_tick  = stop_last;
    assign shreg_shifted = shreg >> 1;

    // NOTE: every register below updates with <= so all flops see the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if ((state == IDLE) || pop || s_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= START;
                        shreg    <= fifo_r_data;
                        tick_cnt <= '0;
                        tx       <= 1'b0;
                        tx_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (tick_cnt == 5'd15) begin
                            state    <= DATA;
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            tx       <= shreg[0];
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (tick_cnt == 5'd15) begin
                            tick_cnt <= '0;
                            shreg    <= shreg_shifted;
                            if (bit_cnt == 3'(DBIT - 1)) begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                tx      <= shreg_shifted[0];
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (tick_cnt == 5'(SB_TICK - 1)) begin
                            tick_cnt <= '0;
                            // Chain straight into the next start bit when another word is waiting.
                            if (pop) begin
                                state <= START;
                                shreg <= fifo_r_data;
                                tx    <= 1'b0;
                            end else begin
                                state   <= IDLE;
                                tx      <= 1'b1;
                                tx_busy <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: two instances (1 and 2 stop bits) fed by queue-based FIFOs and
// checked every cycle against a frame-offset model of the serial line.
module tb_uart_fifo_tx;

    localparam int DBIT   = 8;
    localparam int DVSR   = 4;
    localparam int DVSR_W = 4;
    localparam int BIT_T  = 16 * DVSR;

    logic       clk = 1'b0;
    logic       reset;
    logic       empty_a, rd_a, tx_a, busy_a, done_a;
    logic       empty_b, rd_b, tx_b, busy_b, done_b;
    logic [7:0] data_a, data_b;

    uart_fifo_tx #(.DBIT(DBIT), .SB_TICK(16), .DVSR(DVSR), .DVSR_W(DVSR_W)) dut (
        .clk(clk), .reset(reset), .fifo_empty(empty_a), .fifo_r_data(data_a),
        .fifo_rd(rd_a), .tx(tx_a), .tx_busy(busy_a), .tx_done_tick(done_a)
    );

    uart_fifo_tx #(.DBIT(DBIT), .SB_TICK(32), .DVSR(DVSR), .DVSR_W(DVSR_W)) dut_sb2 (
        .clk(clk), .reset(reset), .fifo_empty(empty_b), .fifo_r_data(data_b),
        .fifo_rd(rd_b), .tx(tx_b), .tx_busy(busy_b), .tx_done_tick(done_b)
    );

    always #5 clk = ~clk;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] popped_a[$];
    logic       hide_a;
    int         pos_a = -1;
    int         pos_b = -1;
    logic [7:0] word_a, word_b;
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_done_a, n_busy_a, n_busy_b, n_pop_b;

    // Expected line level at a given cycle offset within a frame (offset 0 = first start-bit clk).
    function automatic logic line_bit(input logic [7:0] word, input int pos);
        int j;
        j = pos / BIT_T;
        if (j == 0) return 1'b0;
        if (j <= DBIT) return word[j-1];
        return 1'b1;
    endfunction

    task automatic model_cycle(input string tag, input int sb, inout int pos, inout logic [7:0] word,
                               input logic empty, input logic [7:0] head,
                               input logic o_tx, input logic o_busy, input logic o_done, input logic o_rd);
        logic e_tx, e_busy, e_done, e_rd;
        int   len;
        len = (16 * (1 + DBIT) + sb) * DVSR;
        if (reset) begin
            e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_rd = 1'b0;
            pos = -1;
        end else if (pos < 0) begin
            e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_rd = ~empty;
        end else begin
            e_tx   = line_bit(word, pos);
            e_busy = 1'b1;
            e_done = (pos == len - 1);
            e_rd   = e_done && !empty;
        end
        n_checks++;
        if ({o_tx, o_busy, o_done, o_rd} !== {e_tx, e_busy, e_done, e_rd}) begin
            n_fail++;
            $display("FAIL %s at %0t: tx/busy/done/rd got %b%b%b%b expected %b%b%b%b (frame pos %0d)",
                     tag, $time, o_tx, o_busy, o_done, o_rd, e_tx, e_busy, e_done, e_rd, pos);
        end
        if (!reset) begin
            if (pos >= 0) pos++;
            if (pos == len) pos = -1;
            if (e_rd) begin
                word = head;
                pos  = 0;
            end
        end
    endtask

    task automatic refresh();
        empty_a = hide_a || (q_a.size() == 0);
        data_a  = (q_a.size() != 0) ? q_a[0] : 8'h00;
        empty_b = (q_b.size() == 0);
        data_b  = (q_b.size() != 0) ? q_b[0] : 8'h00;
    endtask

    // One clock: check both lines at the falling edge, then retire pops just after the rising edge.
    task automatic step();
        logic       ra, rb;
        logic [7:0] tmp;
        @(negedge clk);
        model_cycle("line_a", 16, pos_a, word_a, empty_a, data_a, tx_a, busy_a, done_a, rd_a);
        model_cycle("line_b", 32, pos_b, word_b, empty_b, data_b, tx_b, busy_b, done_b, rd_b);
        ra = rd_a;
        rb = rd_b;
        if (done_a) n_done_a++;
        if (busy_a) n_busy_a++;
        if (busy_b) n_busy_b++;
        @(posedge clk);
        #1;
        if (ra && q_a.size() != 0) popped_a.push_back(q_a.pop_front());
        if (rb && q_b.size() != 0) begin
            tmp = q_b.pop_front();
            n_pop_b++;
        end
        refresh();
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        hide_a = 1'b0;
        refresh();
        while (!(pos_a < 0 && pos_b < 0 && q_a.size() == 0 && q_b.size() == 0) && n < budget) begin
            step();
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s drain timeout: %0d cycles, required < %0d", tag, n, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        q_a.push_back(8'h11);
        refresh();
        repeat (5) step();
        reset = 1'b0;
        #1;
        n_checks++;
        if (rd_a !== 1'b1) begin
            n_fail++;
            $display("FAIL pop_after_release: fifo_rd got %b required 1", rd_a);
        end
        drain("reset", 1000);
        n_checks++;
        if (popped_a.size() != 1 || popped_a[0] !== 8'h11) begin
            n_fail++;
            $display("FAIL reset_word: popped %0d words, required 1 word 0x11", popped_a.size());
        end
    endtask

    task automatic test_single();
        popped_a.delete();
        n_done_a = 0;
        q_a.push_back(8'hA5);
        refresh();
        drain("single", 800);
        repeat (3) step();
        n_checks++;
        if (popped_a.size() != 1 || n_done_a != 1) begin
            n_fail++;
            $display("FAIL single_counts: pops %0d done %0d, required 1 and 1", popped_a.size(), n_done_a);
        end
    endtask

    task automatic test_back_to_back();
        popped_a.delete();
        n_done_a = 0;
        n_busy_a = 0;
        q_a.push_back(8'h00);
        q_a.push_back(8'hFF);
        refresh();
        drain("b2b", 1500);
        n_checks++;
        if (n_busy_a != 1280) begin
            n_fail++;
            $display("FAIL b2b_active: busy cycles %0d required 1280", n_busy_a);
        end
        n_checks++;
        if (n_done_a != 2 || popped_a.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_counts: done %0d pops %0d, required 2 and 2", n_done_a, popped_a.size());
        end
    endtask

    task automatic test_two_stop_bits();
        n_busy_b = 0;
        n_pop_b  = 0;
        q_b.push_back(8'h55);
        refresh();
        drain("sb2", 900);
        n_checks++;
        if (n_busy_b != 704 || n_pop_b != 1) begin
            n_fail++;
            $display("FAIL sb2_frame: busy cycles %0d pops %0d, required 704 and 1", n_busy_b, n_pop_b);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        popped_a.delete();
        q_a.push_back(8'h3C);
        q_a.push_back(8'h81);
        refresh();
        n = 0;
        while (pos_a != 4 * BIT_T + 20 && n < 500) begin
            step();
            n++;
        end
        n_checks++;
        if (n >= 500) begin
            n_fail++;
            $display("FAIL mid_reach_bit3: %0d cycles, required < 500", n);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({tx_a, busy_a, rd_a} !== 3'b100) begin
            n_fail++;
            $display("FAIL mid_async_reset: tx/busy/rd got %b%b%b required 100", tx_a, busy_a, rd_a);
        end
        repeat (3) step();
        reset = 1'b0;
        n_done_a = 0;
        drain("mid", 1000);
        n_checks++;
        if (popped_a.size() != 2 || popped_a[0] !== 8'h3C || popped_a[1] !== 8'h81 || n_done_a != 1) begin
            n_fail++;
            $display("FAIL mid_words: pops %0d done %0d, required 0x3C,0x81 and 1 frame",
                     popped_a.size(), n_done_a);
        end
    endtask

    task automatic test_empty_toggle();
        logic [7:0] sent[$];
        logic [7:0] w;
        int         bad;
        popped_a.delete();
        n_done_a = 0;
        for (int i = 0; i < 4; i++) begin
            w = 8'($urandom);
            sent.push_back(w);
            q_a.push_back(w);
        end
        for (int c = 0; c < 3000; c++) begin
            hide_a = 1'($urandom_range(0, 1));
            refresh();
            step();
        end
        drain("toggle", 3000);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (i >= popped_a.size() || popped_a[i] !== sent[i]) bad++;
        end
        n_checks++;
        if (bad != 0 || popped_a.size() != 4 || n_done_a != 4) begin
            n_fail++;
            $display("FAIL toggle_counts: pops %0d done %0d wrong words %0d, required 4 4 0",
                     popped_a.size(), n_done_a, bad);
        end
    endtask

    initial begin
        reset  = 1'b1;
        hide_a = 1'b0;
        n_done_a = 0;
        n_busy_a = 0;
        n_busy_b = 0;
        n_pop_b  = 0;
        refresh();
        test_reset();
        test_single();
        test_back_to_back();
        test_two_stop_bits();
        test_reset_mid_frame();
        test_empty_toggle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_fifo_tx.md
Name: uart_fifo_tx

Overview:
UART transmitter that drains a show-ahead FIFO. While the FIFO is non-empty, it pops one word, latches it, and serialises it on `tx`: start bit, DBIT data bits LSB first, then stop bits. It contains its own baud-tick divider with 16x oversampling. It sits on the consumer (read) side of the TX FIFO and is the counterpart of the RX path that fills the RX FIFO.

Parameters:
DBIT, 8, data bits per frame (1..8)
SB_TICK, 16, stop length in oversample ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2; max 32)
DVSR, 163, clocks per oversample tick (50 MHz / (16*19200)); must be >= 2
DVSR_W, 8, width of the baud divider counter; 2**DVSR_W > DVSR

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
fifo_empty  in  1  FIFO empty flag
fifo_r_data  in  DBIT  FIFO head word; valid combinationally while fifo_empty=0
fifo_rd  out  1  FIFO pop strobe, combinational, one clk per popped word
tx  out  1  serial line, registered, idle high
tx_busy  out  1  high from the first start-bit cycle to the last stop cycle
tx_done_tick  out  1  one-clk pulse in the last stop-bit cycle of each frame

Behaviour:
- Reset values (async, immediate): state=idle, tx=1, tx_busy=0, tx_done_tick=0; all counters 0. fifo_rd is forced 0 while reset=1.
- States: idle, start, data, stop.
- Baud divider: counts 0..DVSR-1 and asserts s_tick when the count equals DVSR-1. It is held at 0 in idle and cleared on every pop, so each frame is tick-aligned to its pop.
- idle -> start: fifo_rd = (state==idle) & ~fifo_empty.
  - On that edge: shift register <= fifo_r_data, tick count <= 0, tx <= 0.
  - tx is 0 from the cycle after the pop.
- start: tx=0 for exactly 16*DVSR clks (16 s_ticks). On the 16th s_tick: go to data, bit count <= 0, tx <= shreg[0].
- data: each bit is held 16*DVSR clks, then the shift register shifts right and the bit count increments. After bit DBIT-1: go to stop, tx <= 1.
- stop: tx=1 for SB_TICK*DVSR clks. tx_done_tick=1 during the cycle of the SB_TICK-th s_tick. Then:
  - fifo_empty=0: fifo_rd=1 in that same cycle and go directly to start. Back-to-back frames have no idle gap.
  - fifo_empty=1: go to idle.
- fifo_rd is never asserted in start or data, or in stop before the final tick. The FIFO is never popped while fifo_empty=1.
- Frame length: (16*(1+DBIT)+SB_TICK)*DVSR clks, counted from the first tx=0 cycle to the first cycle after the stop period.
- Widths:
  - tick counter: 5 bits, compares against 15 (start and data) or SB_TICK-1 (stop).
  - bit counter: 3 bits, compares against DBIT-1.
- fifo_empty changes mid-frame are ignored; it is sampled only in idle and at the final stop tick.
- Reset mid-frame: tx returns to 1 asynchronously and the in-flight word is discarded (not re-read). After reset is released, a still non-empty FIFO is popped in the first idle cycle.
- tx is glitch-free: driven only from a flop.

Test Plan:
(All with DVSR=4, DBIT=8, SB_TICK=16, so bit time = 64 clks.)
1. Reset asserted with fifo_empty=0 -> tx=1, fifo_rd=0, tx_busy=0 throughout reset; first pop occurs in the first clk after release.
2. Single word 0xA5, then FIFO empty -> one fifo_rd pulse. tx sequence: 0 for 64 clks, then bits 1,0,1,0,0,1,0,1 (64 clks each), then 1 for 64 clks. tx_done_tick in the last stop clk; then idle with tx_busy=0.
3. Words 0x00, 0xFF back-to-back -> second fifo_rd coincides with the first frame's tx_done_tick. The second start bit begins on the very next clk; no extra high cycle; total 1280 clks of activity.
4. SB_TICK=32 with word 0x55 -> stop high for 128 clks; frame 704 clks.
5. reset pulsed during data bit 3 of 0x3C -> tx=1 in the same cycle as reset. After release, the next FIFO word (0x81) is sent complete and correct, and 0x3C is not resent.
6. fifo_empty toggling during data bits -> no fifo_rd until the final stop tick; pop count equals frame count.
